exec_rsv_station_age: RTL and testbench

EXEC_RSV_STATION_AGE -- requirements
Module: exec_rsv_station_age

---
 rtl/exec_rsv_station_age.sv | 135 +++++++++++++
 tb/tb_exec_rsv_station_age.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/exec_rsv_station_age.sv
// Age-ordered reservation station: compacting queue, oldest-ready issue, CDB wakeup.
// Optional RSV_CDB_BYPASS_EN: wake operands of a write against the same-cycle CDB.
module exec_rsv_station_age #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32,
    parameter int TAG_W = 6,
    parameter int OP_W  = 44,
    localparam int ENTRY_W = OP_W + 2 * (XLEN + 1 + TAG_W),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_flush,
    input  logic               i_wr_en,
    input  logic [ENTRY_W-1:0] i_wr_entry,
    output logic               o_full,
    output logic               o_empty,
    output logic [CNT_W-1:0]   o_count,
    input  logic               i_cdb_valid,
    input  logic [TAG_W-1:0]   i_cdb_tag,
    input  logic [XLEN-1:0]    i_cdb_data,
    output logic               o_issue_valid,
    output logic [ENTRY_W-1:0] o_issue_entry,
    input  logic               i_issue_ack
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int OPL    = XLEN + 1 + TAG_W;
    localparam int R2_TAG = 0;
    localparam int R2_RDY = TAG_W;
    localparam int R2_DAT = TAG_W + 1;
    localparam int R1_TAG = OPL;
    localparam int R1_RDY = OPL + TAG_W;
    localparam int R1_DAT = OPL + TAG_W + 1;

    logic [ENTRY_W-1:0] ent_q [DEPTH];
    logic [ENTRY_W-1:0] ent_d [DEPTH];
    logic [ENTRY_W-1:0] ext   [DEPTH+1];
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [CNT_W-1:0]   base;
    logic [IDX_W-1:0]   sel;
    logic               hit;
    logic               fire;
    logic               accept;
    logic [ENTRY_W-1:0] wr_word;
    logic [ENTRY_W-1:0] shifted;

    function automatic logic [ENTRY_W-1:0] wake(
        input logic [ENTRY_W-1:0] e,
        input logic               v,
        input logic [TAG_W-1:0]   t,
        input logic [XLEN-1:0]    d
    );
        logic [ENTRY_W-1:0] r;
        r = e;
        if (v && !e[R1_RDY] && e[R1_TAG +: TAG_W] == t) begin
            r[R1_DAT +: XLEN] = d;
            r[R1_RDY]         = 1'b1;
        end
        if (v && !e[R2_RDY] && e[R2_TAG +: TAG_W] == t) begin
            r[R2_DAT +: XLEN] = d;
            r[R2_RDY]         = 1'b1;
        end
        return r;
    endfunction

    // Downward scan leaves the lowest (oldest) ready slot selected.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (CNT_W'(i) < count_q && ent_q[i][R1_RDY] && ent_q[i][R2_RDY]) begin
                hit = 1'b1;
                sel = IDX_W'(i);
            end
        end
    end

    assign o_issue_valid = hit;
    assign o_issue_entry = hit ? ent_q[sel] : '0;
    assign o_count       = count_q;
    assign o_full        = (count_q == CNT_W'(DEPTH));
    assign o_empty       = (count_q == '0);

`ifdef RSV_CDB_BYPASS_EN
    assign wr_word = wake(i_wr_entry, i_cdb_valid, i_cdb_tag, i_cdb_data);
`else
    assign wr_word = i_wr_entry;
`endif

    always_comb begin
        fire    = hit & i_issue_ack;
        accept  = i_wr_en & (!o_full | fire);
        base    = count_q - CNT_W'(fire);
        count_d = base + CNT_W'(accept);
        shifted = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ext[k] = ent_q[k];
        end
        ext[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // Slots at or above the issued one pull from their younger neighbour.
            shifted = (fire && CNT_W'(i) >= CNT_W'(sel)) ? ext[i+1] : ext[i];
            if (CNT_W'(i) < base) begin
                ent_d[i] = wake(shifted, i_cdb_valid, i_cdb_tag, i_cdb_data);
            end else if (accept && CNT_W'(i) == base) begin
                ent_d[i] = wr_word;
            end else begin
                ent_d[i] = '0;
            end
        end
        if (i_flush) begin
            count_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i] = '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule

// File: tb/tb_exec_rsv_station_age.sv
// Randomized + directed bench for exec_rsv_station_age against a queue model.
// Honours RSV_CDB_BYPASS_EN in the model when defined.
module tb_exec_rsv_station_age;

    localparam int DEPTH   = 8;
    localparam int ENTRY_W = 122;

    typedef struct {
        logic [43:0] pl;
        logic [31:0] d1;
        logic        r1;
        logic [5:0]  t1;
        logic [31:0] d2;
        logic        r2;
        logic [5:0]  t2;
    } ent_t;

    logic               i_clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic               i_flush = 1'b0;
    logic               i_wr_en = 1'b0;
    logic [ENTRY_W-1:0] i_wr_entry = '0;
    logic               o_full;
    logic               o_empty;
    logic [3:0]         o_count;
    logic               i_cdb_valid = 1'b0;
    logic [5:0]         i_cdb_tag = '0;
    logic [31:0]        i_cdb_data = '0;
    logic               o_issue_valid;
    logic [ENTRY_W-1:0] o_issue_entry;
    logic               i_issue_ack = 1'b0;

    exec_rsv_station_age dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_wr_en(i_wr_en), .i_wr_entry(i_wr_entry),
        .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
        .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag),
        .i_cdb_data(i_cdb_data), .o_issue_valid(o_issue_valid),
        .o_issue_entry(o_issue_entry), .i_issue_ack(i_issue_ack)
    );

    always #5 i_clk = ~i_clk;

    int   errors = 0;
    int   checks = 0;
    ent_t q[$];
    ent_t z = '{default: 0};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] pack(input ent_t e);
        return {e.pl, e.d1, e.r1, e.t1, e.d2, e.r2, e.t2};
    endfunction

    function automatic ent_t mk(input logic r1, input logic [5:0] t1,
                                input logic r2, input logic [5:0] t2);
        ent_t e;
        e.pl = {12'($urandom), $urandom};
        e.d1 = $urandom;
        e.d2 = $urandom;
        e.r1 = r1; e.t1 = t1;
        e.r2 = r2; e.t2 = t2;
        return e;
    endfunction

    function automatic ent_t wake(input ent_t e, input logic v,
                                  input logic [5:0] t, input logic [31:0] d);
        ent_t r = e;
        if (v && !r.r1 && r.t1 == t) begin r.r1 = 1'b1; r.d1 = d; end
        if (v && !r.r2 && r.t2 == t) begin r.r2 = 1'b1; r.d2 = d; end
        return r;
    endfunction

    function automatic int oldest_ready();
        foreach (q[k]) if (q[k].r1 && q[k].r2) return k;
        return -1;
    endfunction

    task automatic step(input logic wr, input ent_t e, input logic cv,
                        input logic [5:0] ct, input logic [31:0] cd,
                        input logic ack, input logic fl);
        int  idx;
        logic fire;
        i_wr_en = wr; i_wr_entry = pack(e);
        i_cdb_valid = cv; i_cdb_tag = ct; i_cdb_data = cd;
        i_issue_ack = ack; i_flush = fl;
        #1;
        idx = oldest_ready();
        check("issue_valid", o_issue_valid, idx >= 0);
        check("issue_entry", o_issue_entry, idx >= 0 ? pack(q[idx]) : '0);
        check("count", o_count, q.size());
        check("full", o_full, q.size() == DEPTH);
        check("empty", o_empty, q.size() == 0);
        @(posedge i_clk);
        fire = (idx >= 0) && ack;
        if (fl) begin
            q.delete();
        end else begin
            logic can_wr = wr && (q.size() < DEPTH || fire);
            if (fire) q.delete(idx);
            foreach (q[k]) q[k] = wake(q[k], cv, ct, cd);
`ifdef RSV_CDB_BYPASS_EN
            if (can_wr) q.push_back(wake(e, cv, ct, cd));
`else
            if (can_wr) q.push_back(e);
`endif
        end
        @(negedge i_clk);
    endtask

    task automatic idle(input logic ack);
        step(1'b0, z, 1'b0, 6'd0, 32'd0, ack, 1'b0);
    endtask

    task automatic put(input ent_t e, input logic ack);
        step(1'b1, e, 1'b0, 6'd0, 32'd0, ack, 1'b0);
    endtask

    initial begin
        #1;
        check("rst_count", o_count, 0);
        check("rst_empty", o_empty, 1);
        check("rst_full", o_full, 0);
        check("rst_valid", o_issue_valid, 0);
        check("rst_entry", o_issue_entry, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // three ready entries drain in write order
        for (int i = 0; i < 3; i++) put(mk(1, 0, 1, 0), 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("drain_empty", o_empty, 1);

        // younger ready entry overtakes a waiting older one, then wake
        put(mk(0, 6'd5, 1, 0), 1'b0);
        put(mk(1, 0, 1, 0), 1'b0);
        idle(1'b1);
        step(1'b0, z, 1'b1, 6'd5, 32'hDEADBEEF, 1'b1, 1'b0);
        check("wake_valid", o_issue_valid, 1);
        check("wake_data", o_issue_entry[77:46], 32'hDEADBEEF);
        idle(1'b1);

        // fill, drop when full, write alongside fire
        put(mk(1, 0, 1, 0), 1'b0);
        for (int i = 1; i < DEPTH; i++) put(mk(0, 6'd60, 1, 0), 1'b0);
        put(mk(1, 0, 1, 0), 1'b0);
        check("full_cnt", o_count, DEPTH);
        put(mk(1, 0, 1, 0), 1'b1);
        check("fire_wr_cnt", o_count, DEPTH);
        step(1'b0, z, 1'b0, 6'd0, 32'd0, 1'b0, 1'b1);

        // same-cycle CDB match on dispatch
        step(1'b1, mk(1, 0, 0, 6'd9), 1'b1, 6'd9, 32'h1234, 1'b0, 1'b0);
`ifdef RSV_CDB_BYPASS_EN
        check("bypass", o_issue_valid, 1);
`else
        check("bypass", o_issue_valid, 0);
`endif
        idle(1'b0);
        step(1'b0, z, 1'b1, 6'd9, 32'h5678, 1'b0, 1'b0);
        check("late_wake", o_issue_valid, 1);
        idle(1'b1);

        // flush overrides write and fire
        for (int i = 0; i < 4; i++) put(mk(1, 0, 1, 0), 1'b0);
        step(1'b1, mk(1, 0, 1, 0), 1'b0, 6'd0, 32'd0, 1'b1, 1'b1);
        check("flush_cnt", o_count, 0);
        check("flush_valid", o_issue_valid, 0);

        // asynchronous reset mid-fill
        for (int i = 0; i < 3; i++) put(mk(1, 0, 0, 6'd3), 1'b0);
        #2 i_rst_n = 1'b0;
        #1;
        check("arst_count", o_count, 0);
        check("arst_empty", o_empty, 1);
        check("arst_full", o_full, 0);
        check("arst_valid", o_issue_valid, 0);
        check("arst_entry", o_issue_entry, 0);
        q.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        put(mk(1, 0, 1, 0), 1'b0);
        check("post_rst_wr", o_count, 1);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 9) < 6,
                 mk($urandom_range(0, 2) != 0, 6'($urandom_range(0, 7)),
                    $urandom_range(0, 2) != 0, 6'($urandom_range(0, 7))),
                 $urandom_range(0, 1) == 1, 6'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
